// File: rtl/collide_response_pkg.sv
// Shared game definitions: collision FSM states, Collide bit positions,
// and the frame-counter load helper used by frame-rate blocks.
package collide_response_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_KNOCK   = 2'd1,
      ST_RECOVER = 2'd2,
      ST_OVER    = 2'd3
   } cr_state_e;

   localparam int COL_FRONT = 0;
   localparam int COL_LEFT  = 1;
   localparam int COL_REAR  = 2;
   localparam int COL_RIGHT = 3;

   // Rear contact never causes a response, so it is masked out of hit decode.
   localparam logic [3:0] HIT_MASK    = ~(4'b0001 << COL_REAR);
   localparam logic [9:0] SPEED_NOCAP = 10'h3FF;
   localparam logic [7:0] CNT8_MAX    = 8'hFF;

   // Frame counters are 8 bits; a zero-length period still lasts one frame.
   function automatic logic [7:0] frames_ld(input int unsigned n);
      logic [7:0] v;
      if (n == 0)
         v = 8'd1;
      else if (n > 255)
         v = 8'hFF;
      else
         v = n[7:0];
      return v;
   endfunction

endpackage

// File: rtl/collide_response_frame_tick_gen.sv
// Two-flop synchroniser for a frame strobe plus rising-edge detector;
// emits a single-clk tick per frame, reusable by any frame-rate block.
module frame_tick_gen (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_frame,
   output logic o_tick
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_frame;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_tick = r_sync2 & ~r_prev;

endmodule

// File: rtl/collide_response.sv
// Per-frame collision response: knockback push, recovery invulnerability,
// speed capping after front hits, and sticky game-over after too many crashes.
module collide_response
   import collide_response_pkg::*;
#(
   parameter int KNOCK_FRAMES   = 8,
   parameter int RECOVER_FRAMES = 60,
   parameter int PUSH_STEP      = 3,
   parameter int SLOW_SPEED     = 1,
   parameter int CRASH_LIMIT    = 3
) (
   input  logic              clk,
   input  logic              Reset_n,
   input  logic              frame_clk,
   input  logic [3:0]        Collide,
   output logic signed [9:0] XPush,
   output logic [9:0]        SpeedCap,
   output logic              Invuln,
   output logic [7:0]        HitCount,
   output logic              GameOver
);

   localparam logic [7:0] KNOCK_LD = frames_ld(KNOCK_FRAMES);
   localparam logic [7:0] RECOV_LD = frames_ld(RECOVER_FRAMES);
   localparam logic [9:0] PUSH_POS = PUSH_STEP[9:0];
   localparam logic [9:0] PUSH_NEG = -PUSH_POS;
   localparam logic [9:0] SLOW_CAP = SLOW_SPEED[9:0];
   localparam int         CL_SAT   = (CRASH_LIMIT > 255) ? 255 : CRASH_LIMIT;
   localparam logic [7:0] CRASH_LIM = CL_SAT[7:0];

   logic       w_tick;
   logic [3:0] w_hit_bits;
   logic       w_any_hit;
   logic       w_front;
   logic       w_left;
   logic       w_right;
   logic [7:0] w_hits_nxt;
   logic [7:0] w_crash_nxt;

   cr_state_e  r_state;
   logic [7:0] r_cnt;
   logic [7:0] r_crash;
   logic [9:0] r_xpush;
   logic [9:0] r_cap;
   logic       r_inv;
   logic [7:0] r_hits;
   logic       r_over;

   frame_tick_gen u_tick (
      .i_clk   (clk),
      .i_rst_n (Reset_n),
      .i_frame (frame_clk),
      .o_tick  (w_tick)
   );

   assign w_hit_bits  = Collide & HIT_MASK;
   assign w_any_hit   = |w_hit_bits;
   assign w_front     = w_hit_bits[COL_FRONT];
   assign w_left      = w_hit_bits[COL_LEFT];
   assign w_right     = w_hit_bits[COL_RIGHT];
   assign w_hits_nxt  = (r_hits == CNT8_MAX) ? r_hits : r_hits + 8'd1;
   assign w_crash_nxt = (r_crash == CNT8_MAX) ? r_crash : r_crash + 8'd1;

   always_ff @(posedge clk) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
         r_crash <= 8'd0;
         r_xpush <= 10'd0;
         r_cap   <= SPEED_NOCAP;
         r_inv   <= 1'b0;
         r_hits  <= 8'd0;
         r_over  <= 1'b0;
      end else if (w_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_hit) begin
                  r_hits <= w_hits_nxt;
                  r_inv  <= 1'b1;
                  if (w_front) begin
                     r_crash <= w_crash_nxt;
                     if (w_crash_nxt >= CRASH_LIM) begin
                        // OVER ignores all further collisions, so it stays invulnerable.
                        r_state <= ST_OVER;
                        r_over  <= 1'b1;
                        r_cap   <= 10'd0;
                        r_xpush <= 10'd0;
                     end else begin
                        r_state <= ST_RECOVER;
                        r_cnt   <= RECOV_LD;
                        r_cap   <= SLOW_CAP;
                     end
                  end else begin
                     // A left hit shoves rightward; simultaneous sides cancel.
                     r_state <= ST_KNOCK;
                     r_cnt   <= KNOCK_LD;
                     if (w_left && w_right)
                        r_xpush <= 10'd0;
                     else if (w_left)
                        r_xpush <= PUSH_POS;
                     else
                        r_xpush <= PUSH_NEG;
                  end
               end
            end
            ST_KNOCK: begin
               if (r_cnt <= 8'd1) begin
                  r_xpush <= 10'd0;
                  r_cnt   <= RECOV_LD;
                  r_state <= ST_RECOVER;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            ST_RECOVER: begin
               if (r_cnt <= 8'd1) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= 8'd0;
                  r_inv   <= 1'b0;
                  r_cap   <= SPEED_NOCAP;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            ST_OVER: begin
               r_state <= ST_OVER;
               r_over  <= 1'b1;
               r_cap   <= 10'd0;
               r_xpush <= 10'd0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign XPush    = r_xpush;
   assign SpeedCap = r_cap;
   assign Invuln   = r_inv;
   assign HitCount = r_hits;
   assign GameOver = r_over;

endmodule

// File: tb/tb_collide_response.sv
// Directed scenarios for collide_response; expected outputs are queued per frame
// and a separate monitor compares them against the DUT.
module tb_collide_response;

   logic              clk       = 1'b0;
   logic              Reset_n   = 1'b0;
   logic              frame_clk = 1'b0;
   logic [3:0]        Collide   = 4'b0000;
   logic signed [9:0] XPush;
   logic [9:0]        SpeedCap;
   logic              Invuln;
   logic [7:0]        HitCount;
   logic              GameOver;

   collide_response dut (
      .clk       (clk),
      .Reset_n   (Reset_n),
      .frame_clk (frame_clk),
      .Collide   (Collide),
      .XPush     (XPush),
      .SpeedCap  (SpeedCap),
      .Invuln    (Invuln),
      .HitCount  (HitCount),
      .GameOver  (GameOver)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] xp;
      logic [9:0] cap;
      logic       inv;
      logic [7:0] hits;
      logic       over;
   } obs_t;

   obs_t  exp_q[$];
   string name_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   event  ev_chk;

   function automatic obs_t mk(input logic [9:0] xp, input logic [9:0] cap,
                               input logic inv, input logic [7:0] hits, input logic over);
      obs_t o;
      o.xp = xp; o.cap = cap; o.inv = inv; o.hits = hits; o.over = over;
      return o;
   endfunction

   task automatic expect_out(input string nm, input obs_t e);
      exp_q.push_back(e);
      name_q.push_back(nm);
      -> ev_chk;
   endtask

   // One frame: strobe high for hi_clks clk cycles, then low for 4.
   task automatic frame(input logic [3:0] col, input int hi_clks);
      Collide   = col;
      frame_clk = 1'b1;
      repeat (hi_clks) @(posedge clk);
      #1;
      frame_clk = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      Collide = 4'b0000;
   endtask

   // Monitor: outputs are sampled a little after the check request.
   initial begin
      forever begin
         @(ev_chk);
         #2;
         while (exp_q.size() > 0) begin
            obs_t  e;
            obs_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = mk(XPush, SpeedCap, Invuln, HitCount, GameOver);
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL %s @%0t: got xp=%h cap=%h inv=%b hits=%0d over=%b, want xp=%h cap=%h inv=%b hits=%0d over=%b",
                        nm, $time, a.xp, a.cap, a.inv, a.hits, a.over,
                        e.xp, e.cap, e.inv, e.hits, e.over);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t idle0;
      obs_t over_e;
      int   guard;
      idle0 = mk(10'd0, 10'h3FF, 1'b0, 8'd0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      expect_out("reset_state", idle0);
      Reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      for (int k = 0; k < 10; k++) begin
         frame(4'b0100, 4);
         expect_out("rear_only", idle0);
      end

      // Left hit delivered with frame_clk held high for 50 clk: only one tick may occur.
      frame(4'b0010, 50);
      expect_out("left_hit_k0", mk(10'd3, 10'h3FF, 1'b1, 8'd1, 1'b0));
      for (int k = 1; k <= 68; k++) begin
         logic [3:0] col;
         col = (k == 3 || k == 30) ? 4'b0001 : ((k == 5) ? 4'b1000 : 4'b0000);
         frame(col, 4);
         expect_out("left_hit", mk((k <= 7) ? 10'd3 : 10'd0, 10'h3FF, (k <= 67), 8'd1, 1'b0));
      end

      frame(4'b1010, 4);
      expect_out("both_sides_k0", mk(10'd0, 10'h3FF, 1'b1, 8'd2, 1'b0));
      for (int k = 1; k <= 68; k++) begin
         frame(4'b0000, 4);
         expect_out("both_sides", mk(10'd0, 10'h3FF, (k <= 67), 8'd2, 1'b0));
      end

      frame(4'b0011, 4);
      expect_out("front_prio_k0", mk(10'd0, 10'd1, 1'b1, 8'd3, 1'b0));
      for (int k = 1; k <= 60; k++) begin
         frame((k == 10) ? 4'b0010 : 4'b0000, 4);
         expect_out("front_recover", mk(10'd0, (k <= 59) ? 10'd1 : 10'h3FF, (k <= 59), 8'd3, 1'b0));
      end

      frame(4'b1000, 4);
      expect_out("right_hit_k0", mk(10'h3FD, 10'h3FF, 1'b1, 8'd4, 1'b0));
      for (int k = 1; k <= 3; k++) begin
         frame(4'b0000, 4);
         expect_out("right_hit", mk(10'h3FD, 10'h3FF, 1'b1, 8'd4, 1'b0));
      end
      Reset_n = 1'b0;
      @(posedge clk);
      #1;
      Reset_n = 1'b1;
      expect_out("mid_knock_reset", idle0);
      frame(4'b0000, 4);
      expect_out("post_reset_frame", idle0);

      // Crash counter restarts from zero after reset; the third front hit ends the game.
      for (int h = 1; h <= 2; h++) begin
         frame(4'b0001, 4);
         expect_out("crash_hit", mk(10'd0, 10'd1, 1'b1, h[7:0], 1'b0));
         for (int k = 1; k <= 60; k++) begin
            frame(4'b0000, 4);
            expect_out("crash_recover", mk(10'd0, (k <= 59) ? 10'd1 : 10'h3FF, (k <= 59), h[7:0], 1'b0));
         end
      end
      over_e = mk(10'd0, 10'd0, 1'b1, 8'd3, 1'b1);
      frame(4'b0001, 4);
      expect_out("game_over", over_e);
      frame(4'b1111, 4);
      expect_out("over_collide", over_e);
      for (int k = 0; k < 200; k++) begin
         logic [3:0] col;
         col = 4'(k);
         frame(col, 4);
         expect_out("over_hold", over_e);
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expected responses never checked, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/collide_response.md
COLLIDE_RESPONSE -- requirements
Module: collide_response

Interface
REQ-001 SHALL have parameter KNOCK_FRAMES, default 8, frames of lateral push after a side hit.
REQ-002 SHALL have parameter RECOVER_FRAMES, default 60, invulnerability frames after knockback or front hit.
REQ-003 SHALL have parameter PUSH_STEP, default 3, lateral pixels per frame during knockback.
REQ-004 SHALL have parameter SLOW_SPEED, default 1, speed cap while recovering from a front hit.
REQ-005 SHALL have parameter CRASH_LIMIT, default 3, front hits that end the game.
REQ-006 clk  input  1  system clock; the only clock.
REQ-007 Reset_n  input  1  synchronous, active-low reset.
REQ-008 frame_clk  input  1  frame strobe, sampled as data in the clk domain.
REQ-009 Collide  input  4  per-frame flags: bit0 front, bit1 left, bit2 rear, bit3 right.
REQ-010 XPush  output  10  signed lateral offset to apply this frame; positive means rightward.
REQ-011 SpeedCap  output  10  maximum allowed ground speed; 10'h3FF means no cap.
REQ-012 Invuln  output  1  high while collisions are ignored.
REQ-013 HitCount  output  8  saturating count of accepted hits.
REQ-014 GameOver  output  1  sticky end-of-game flag.

Function
REQ-015 SHALL synchronise frame_clk through two flops and produce a one-clk tick on each rising edge, no later than 3 clk cycles after the edge.
REQ-016 SHALL sample Collide, advance the FSM and update every output only in the clk cycle of tick; outputs SHALL hold between ticks.
REQ-017 FSM states SHALL be IDLE, KNOCK, RECOVER and OVER.
REQ-018 IDLE, front bit set: go to RECOVER, load frame counter with RECOVER_FRAMES, set SpeedCap=SLOW_SPEED, increment HitCount, increment crash counter.
REQ-019 IDLE, exactly one side bit set and front clear: go to KNOCK, load counter with KNOCK_FRAMES, set XPush=+PUSH_STEP for a left hit or -PUSH_STEP for a right hit, increment HitCount.
REQ-020 IDLE, both side bits set and front clear: go to KNOCK with XPush=0; HitCount increments once.
REQ-021 Rear bit alone SHALL be ignored: no state change, no count.
REQ-022 Front SHALL take priority over side bits when set in the same tick.
REQ-023 KNOCK: counter decrements each tick; Collide ignored; at counter==1, XPush=0, reload counter with RECOVER_FRAMES, go to RECOVER.
REQ-024 RECOVER: Invuln=1, Collide ignored, counter decrements each tick; at counter==1, go to IDLE with Invuln=0 and SpeedCap=10'h3FF.
REQ-025 Invuln SHALL also be 1 throughout KNOCK.
REQ-026 When the crash counter reaches CRASH_LIMIT, the FSM SHALL enter OVER instead of RECOVER.
REQ-027 OVER: GameOver=1, SpeedCap=0, XPush=0; the FSM SHALL stay in OVER until reset.
REQ-028 HitCount SHALL saturate at 255 without wrapping.
REQ-029 Frame counters SHALL be 8 bits wide; a parameter value of 0 SHALL behave as 1.

Reset
REQ-030 SHALL put the following in effect at the first clk edge with Reset_n=0, regardless of tick or state:
- state=IDLE
- XPush=0
- SpeedCap=10'h3FF
- Invuln=0
- HitCount=0
- GameOver=0
- crash counter=0
- synchroniser flops=0
REQ-031 A tick pending during reset SHALL be discarded; a reset asserted mid-KNOCK SHALL leave no residual push.

Structure
REQ-032 The FSM state enum and the Collide bit-position constants SHALL reside in the shared game package.
REQ-033 The synchroniser and edge detector SHALL be one sub-module, frame_tick_gen, reusable by other frame-rate blocks.

Verification
REQ-034 Left hit in IDLE -> XPush=+3 for 8 ticks, then 0; Invuln=1 for 68 ticks total; HitCount=1.
REQ-035 Collide=4'b1010 (both sides) -> XPush=0 throughout KNOCK; HitCount=1.
REQ-036 Collide=4'b0011 -> RECOVER with SpeedCap=1 for 60 ticks, then 10'h3FF; XPush=0 throughout.
REQ-037 Three front hits, each after recovery completes -> GameOver=1, SpeedCap=0; a further Collide input and 200 extra ticks cause no change.
REQ-038 Reset_n=0 for one clk during KNOCK with XPush=-3 -> all outputs at reset values on the next clk cycle.
REQ-039 Collide=4'b0100 held for 10 ticks -> no outputs change; frame_clk held high for 50 clk cycles -> exactly one tick.
